// File: rtl/l1b_read_request_gen_pkg.sv
// rtl/l1b_read_request_gen_pkg.sv - shared globals for the L1 buffer read-request generator
// Purpose: address width global (`L1B_ADDR_WIDTH, default 8), the default
//          issue spacing shared with the read-address mux, and the FSM
//          state encoding used by l1b_read_request_gen.
// Ports:   none (package).
`ifndef L1B_ADDR_WIDTH
`define L1B_ADDR_WIDTH 8
`endif

package l1b_read_request_gen_pkg;

  localparam int L1B_ADDR_W          = `L1B_ADDR_WIDTH;
  localparam int L1B_DEFAULT_SPACING = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } reqState_e;

endpackage

// File: rtl/l1b_read_request_gen_if.sv
// rtl/l1b_read_request_gen_if.sv - trigger/issue bus of the L1 buffer read-request generator
// Purpose: bundles the trigger inputs and the issue/status outputs.
//          master = generator side, slave = trigger source / downstream mux.
//          L1B_REQ_COUNT_EN adds R3IssueCount / L1IssueCount.
// Signals: Latency, R3Trig, L1Trig, ClearErr (to generator);
//          WriteAddr, AI, BI, AddressIn1, AddressIn2, R3Overflow,
//          L1Overflow, Busy [, R3IssueCount, L1IssueCount] (from generator).
interface l1b_read_request_gen_if
  import l1b_read_request_gen_pkg::*;
#(
  parameter int ADDR_W = L1B_ADDR_W
);

  logic [ADDR_W-1:0] Latency;
  logic              R3Trig;
  logic              L1Trig;
  logic              ClearErr;
  logic [ADDR_W-1:0] WriteAddr;
  logic              AI;
  logic              BI;
  logic [ADDR_W-1:0] AddressIn1;
  logic [ADDR_W-1:0] AddressIn2;
  logic              R3Overflow;
  logic              L1Overflow;
  logic              Busy;
`ifdef L1B_REQ_COUNT_EN
  logic [15:0]       R3IssueCount;
  logic [15:0]       L1IssueCount;

  modport master (
    input  Latency, R3Trig, L1Trig, ClearErr,
    output WriteAddr, AI, BI, AddressIn1, AddressIn2,
           R3Overflow, L1Overflow, Busy, R3IssueCount, L1IssueCount
  );

  modport slave (
    output Latency, R3Trig, L1Trig, ClearErr,
    input  WriteAddr, AI, BI, AddressIn1, AddressIn2,
           R3Overflow, L1Overflow, Busy, R3IssueCount, L1IssueCount
  );
`else
  modport master (
    input  Latency, R3Trig, L1Trig, ClearErr,
    output WriteAddr, AI, BI, AddressIn1, AddressIn2,
           R3Overflow, L1Overflow, Busy
  );

  modport slave (
    output Latency, R3Trig, L1Trig, ClearErr,
    input  WriteAddr, AI, BI, AddressIn1, AddressIn2,
           R3Overflow, L1Overflow, Busy
  );
`endif

endinterface

// File: rtl/l1b_read_request_gen_fifo.sv
// rtl/l1b_read_request_gen_fifo.sv - request queue (l1b_req_fifo) for one trigger source
// Purpose: synchronous FIFO, W bits x DEPTH entries (DEPTH power of 2).
//          A push while full is accepted only when a pop happens in the
//          same cycle; otherwise it is ignored (the caller flags overflow).
// Ports:   CLK, RST (sync, active-high), push, pushData, pop,
//          full, empty, head (oldest entry, valid when !empty).
module l1b_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign full   = (count == (PW + 1)'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge CLK) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l1b_read_request_gen.sv
// rtl/l1b_read_request_gen.sv - L1 buffer read-request generator (initiator side of read-address mux)
// Purpose: runs the circular write pointer, turns R3/L1 triggers into read
//          addresses (WriteAddr - Latency), queues them per source and
//          issues AI (R3) / BI (L1) pulses at least SPACING cycles apart,
//          R3 first. Optional L1B_REQ_COUNT_EN adds saturating issue counters.
// Ports:   CLK, RST (sync, active-high), bus (l1b_read_request_gen_if.master).
module l1b_read_request_gen
  import l1b_read_request_gen_pkg::*;
#(
  parameter int ADDR_W     = L1B_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SPACING    = L1B_DEFAULT_SPACING
) (
  input logic                    CLK,
  input logic                    RST,
  l1b_read_request_gen_if.master bus
);

  // Last GAP cycle index: ISSUE + (SPACING-2) GAP + IDLE = SPACING cycles per slot.
  localparam logic [3:0] GAP_LAST = 4'(SPACING - 3);

  reqState_e         state;
  reqState_e         stateNext;
  logic [ADDR_W-1:0] writeAddr;
  logic [ADDR_W-1:0] reqAddr;
  logic [ADDR_W-1:0] addrIn1;
  logic [ADDR_W-1:0] addrIn2;
  logic [3:0]        gapCnt;
  logic              srcL1;
  logic              selR3;
  logic              selL1;
  logic              r3Full, r3Empty, r3Pop;
  logic              l1Full, l1Empty, l1Pop;
  logic [ADDR_W-1:0] r3Head, l1Head;
  logic              r3Ovf, l1Ovf;

  assign reqAddr = writeAddr - bus.Latency;

  // The entry stays in the queue through ISSUE and is popped there, so the
  // ISSUE slot still counts as occupancy for overflow purposes.
  assign r3Pop = (state == ISSUE) && !srcL1;
  assign l1Pop = (state == ISSUE) && srcL1;

  l1b_req_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_r3Fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (bus.R3Trig),
    .pushData (reqAddr),
    .pop      (r3Pop),
    .full     (r3Full),
    .empty    (r3Empty),
    .head     (r3Head)
  );

  l1b_req_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_l1Fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (bus.L1Trig),
    .pushData (reqAddr),
    .pop      (l1Pop),
    .full     (l1Full),
    .empty    (l1Empty),
    .head     (l1Head)
  );

  always_comb begin
    stateNext = state;
    selR3     = 1'b0;
    selL1     = 1'b0;
    case (state)
      IDLE: begin
        if (!r3Empty) begin
          selR3     = 1'b1;
          stateNext = ISSUE;
        end else if (!l1Empty) begin
          selL1     = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE:   stateNext = GAP;
      GAP:     if (gapCnt == GAP_LAST) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      writeAddr <= '0;
      gapCnt    <= '0;
      srcL1     <= 1'b0;
      addrIn1   <= '0;
      addrIn2   <= '0;
      r3Ovf     <= 1'b0;
      l1Ovf     <= 1'b0;
    end else begin
      state     <= stateNext;
      writeAddr <= writeAddr + ADDR_W'(1);
      gapCnt    <= (state == GAP) ? gapCnt + 4'd1 : 4'd0;
      // Address registers load on the edge into ISSUE so they are already
      // valid in the pulse cycle and hold until the next issue of that source.
      if (selR3) begin
        srcL1   <= 1'b0;
        addrIn1 <= r3Head;
      end
      if (selL1) begin
        srcL1   <= 1'b1;
        addrIn2 <= l1Head;
      end
      // A new drop wins over ClearErr in the same cycle.
      if (bus.R3Trig && r3Full && !r3Pop) r3Ovf <= 1'b1;
      else if (bus.ClearErr)              r3Ovf <= 1'b0;
      if (bus.L1Trig && l1Full && !l1Pop) l1Ovf <= 1'b1;
      else if (bus.ClearErr)              l1Ovf <= 1'b0;
    end
  end

  assign bus.WriteAddr  = writeAddr;
  assign bus.AI         = (state == ISSUE) && !srcL1;
  assign bus.BI         = (state == ISSUE) && srcL1;
  assign bus.AddressIn1 = addrIn1;
  assign bus.AddressIn2 = addrIn2;
  assign bus.R3Overflow = r3Ovf;
  assign bus.L1Overflow = l1Ovf;
  assign bus.Busy       = !r3Empty || !l1Empty || (state != IDLE);

`ifdef L1B_REQ_COUNT_EN
  logic [15:0] r3Cnt;
  logic [15:0] l1Cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r3Cnt <= '0;
      l1Cnt <= '0;
    end else begin
      if (bus.AI && (r3Cnt != 16'hFFFF)) r3Cnt <= r3Cnt + 16'd1;
      if (bus.BI && (l1Cnt != 16'hFFFF)) l1Cnt <= l1Cnt + 16'd1;
    end
  end

  assign bus.R3IssueCount = r3Cnt;
  assign bus.L1IssueCount = l1Cnt;
`endif

endmodule

// File: tb/tb_l1b_read_request_gen.sv
// tb/tb_l1b_read_request_gen.sv - self-checking bench for l1b_read_request_gen
// Purpose: table-driven directed vectors, hand-written corner sequences and
//          randomized triggers checked against a queue/timestamp reference model.
//          Honours L1B_REQ_COUNT_EN.
module tb_l1b_read_request_gen;

  localparam int SPACING = 4;
  localparam int DEPTH   = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  l1b_read_request_gen_if bus ();

  l1b_read_request_gen #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .SPACING(SPACING)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: per-source queues of addresses, cycle count since reset,
  // time of the last issue pulse and the issue (if any) due in the current cycle.
  logic [7:0] q3[$];
  logic [7:0] q1[$];
  int         k;
  int         lastIssue;
  int         pend;        // 0 none, 1 R3, 2 L1 issuing this cycle
  logic [7:0] wa, ea1, ea2, lat;
  bit         eov3, eov1;
  int         ecnt3, ecnt1;

  typedef struct {
    bit         r3, l1, clr;
    bit         ai, bi, busy;
    logic [7:0] wa, a1, a2;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q3.delete();
    q1.delete();
    k = 0; lastIssue = -100; pend = 0;
    wa = 0; ea1 = 0; ea2 = 0;
    eov3 = 0; eov1 = 0; ecnt3 = 0; ecnt1 = 0;
  endtask

  task automatic check_model();
    chk("WriteAddr", bus.WriteAddr, wa);
    chk("AI", bus.AI, pend == 1);
    chk("BI", bus.BI, pend == 2);
    chk("AddressIn1", bus.AddressIn1, ea1);
    chk("AddressIn2", bus.AddressIn2, ea2);
    chk("R3Overflow", bus.R3Overflow, eov3);
    chk("L1Overflow", bus.L1Overflow, eov1);
    chk("Busy", bus.Busy, (q3.size() != 0) || (q1.size() != 0) || (k - lastIssue <= SPACING - 2));
`ifdef L1B_REQ_COUNT_EN
    chk("R3IssueCount", bus.R3IssueCount, ecnt3);
    chk("L1IssueCount", bus.L1IssueCount, ecnt1);
`endif
  endtask

  // Drive this cycle's inputs and advance the model by one cycle.
  task automatic apply(input bit r3, input bit l1, input bit clr);
    int newPend;
    bus.R3Trig   = r3;
    bus.L1Trig   = l1;
    bus.ClearErr = clr;
    if (pend == 1) begin
      void'(q3.pop_front());
      if (ecnt3 < 65535) ecnt3++;
    end else if (pend == 2) begin
      void'(q1.pop_front());
      if (ecnt1 < 65535) ecnt1++;
    end
    newPend = 0;
    if (k - lastIssue >= SPACING - 1) begin
      if (q3.size() != 0) begin
        newPend = 1; ea1 = q3[0];
      end else if (q1.size() != 0) begin
        newPend = 2; ea2 = q1[0];
      end
    end
    if (clr) begin
      eov3 = 0; eov1 = 0;
    end
    if (r3) begin
      if (q3.size() < DEPTH) q3.push_back(wa - lat);
      else eov3 = 1;
    end
    if (l1) begin
      if (q1.size() < DEPTH) q1.push_back(wa - lat);
      else eov1 = 1;
    end
    wa = wa + 8'd1;
    k++;
    if (newPend != 0) lastIssue = k;
    pend = newPend;
  endtask

  // Call right after a negedge (or at time 0); returns just before cycle 0's negedge.
  task automatic do_reset(input int n);
    RST = 1'b1;
    bus.R3Trig = 0; bus.L1Trig = 0; bus.ClearErr = 0;
    repeat (n) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input bit r3, input bit l1, input bit clr);
    @(negedge CLK);
    check_model();
    apply(r3, l1, clr);
  endtask

  initial begin
    int nbi;
    lat = 8'd10;
    bus.Latency = lat;
    for (int i = 0; i < 22; i++) begin
      tbl[i].r3   = (i == 5) || (i == 12);
      tbl[i].l1   = (i == 12);
      tbl[i].clr  = 0;
      tbl[i].ai   = (i == 7) || (i == 14);
      tbl[i].bi   = (i == 18);
      tbl[i].busy = (i >= 6 && i <= 9) || (i >= 13 && i <= 20);
      tbl[i].wa   = 8'(i);
      tbl[i].a1   = (i < 7) ? 8'h00 : (i < 14) ? 8'hFB : 8'h02;
      tbl[i].a2   = (i < 18) ? 8'h00 : 8'h02;
    end

    // Directed table: single R3 at WriteAddr=5, then simultaneous R3+L1.
    do_reset(3);
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      chk("tbl WriteAddr", bus.WriteAddr, tbl[i].wa);
      chk("tbl AI", bus.AI, tbl[i].ai);
      chk("tbl BI", bus.BI, tbl[i].bi);
      chk("tbl Busy", bus.Busy, tbl[i].busy);
      chk("tbl AddressIn1", bus.AddressIn1, tbl[i].a1);
      chk("tbl AddressIn2", bus.AddressIn2, tbl[i].a2);
      check_model();
      apply(tbl[i].r3, tbl[i].l1, tbl[i].clr);
    end

    // Reset and write-pointer wrap.
    @(negedge CLK);
    do_reset(3);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 0);
      if (i == 256) chk("wrap WriteAddr", bus.WriteAddr, 8'd0);
    end

    // Overflow: 6 back-to-back L1 triggers; the drop coincides with ClearErr.
    @(negedge CLK);
    do_reset(1);
    nbi = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      check_model();
      if (bus.BI === 1'b1) nbi++;
      if (i == 8)  chk("L1Overflow sticky", bus.L1Overflow, 1);
      if (i == 13) chk("L1Overflow cleared", bus.L1Overflow, 0);
      apply(0, i < 6, (i == 5) || (i == 12));
    end
    chk("L1 pulses after overflow", nbi, 5);

    // Priority: L1 backlog, then an R3 trigger takes the next slot.
    @(negedge CLK);
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      check_model();
      if (i == 6)  chk("priority AI", bus.AI, 1);
      if (i == 10) chk("priority BI resumes", bus.BI, 1);
      apply(i == 4, i < 4, 0);
    end

    // Reset one cycle after AI with two R3 requests still queued.
    @(negedge CLK);
    do_reset(1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    @(negedge CLK);
    check_model();
    do_reset(1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0);
    @(negedge CLK);
    chk("Busy after mid-GAP reset", bus.Busy, 0);

    // Randomized: sparse then dense triggers, random latency.
    for (int p = 0; p < 2; p++) begin
      @(negedge CLK);
      lat = 8'($urandom);
      bus.Latency = lat;
      do_reset(2);
      for (int i = 0; i < 1500; i++) begin
        int th;
        th = (p == 0) ? 15 : 45;
        cyc($urandom_range(99) < th, $urandom_range(99) < th, $urandom_range(99) < 5);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
